// File: rtl/tag_check_scheduler.sv
// Tag-check stage sequencer: pops one request from the tag FIFO, pairs it
// with the in-order tag-read response, and presents one hit/miss result.
// It also keeps saturating hit and miss statistics counters.
module tag_check_scheduler #(
  parameter int ADDR_WIDTH   = 64,
  parameter int TID_WIDTH    = 16,
  parameter int INDEX_WIDTH  = 20,
  parameter int OFFSET_WIDTH = 6,
  parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
  parameter int DATA_WIDTH   = 512,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              tag_fifo_empty_i,
  input  logic [ADDR_WIDTH+TID_WIDTH:0]     tag_fifo_rdata_i,
  output logic                              tag_fifo_rden_o,
  input  logic                              rvalid_i,
  input  logic [DATA_WIDTH-1:0]             rdata_i,
  output logic                              rready_o,
  output logic                              res_valid_o,
  input  logic                              res_ready_i,
  output logic                              res_hit_o,
  output logic                              res_dirty_o,
  output logic                              res_write_o,
  output logic [TID_WIDTH-1:0]              res_tid_o,
  output logic [ADDR_WIDTH-1:0]             res_addr_o,
  input  logic                              cnt_clr_i,
  output logic [CNT_WIDTH-1:0]              hit_cnt_o,
  output logic [CNT_WIDTH-1:0]              miss_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT_R = 2'd1,
    S_OUT    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   write_q, write_d;
  logic [TID_WIDTH-1:0]   tid_q, tid_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   hit_q, hit_d;
  logic                   dirty_q, dirty_d;
  logic [CNT_WIDTH-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]   miss_cnt_q, miss_cnt_d;

  logic                   rden;
  logic                   rready;
  logic                   res_valid;
  logic                   handshake;

  // Response bits above the dirty flag carry line data this stage ignores.
  logic                   unused_rdata_hi;
  assign unused_rdata_hi = ^rdata_i[DATA_WIDTH-1:TAG_WIDTH+2];

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Next-state, FIFO pop, response accept and result capture.
  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    tid_d     = tid_q;
    addr_d    = addr_q;
    hit_d     = hit_q;
    dirty_d   = dirty_q;
    rden      = 1'b0;
    rready    = 1'b0;
    res_valid = 1'b0;
    handshake = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!tag_fifo_empty_i) begin
          rden    = 1'b1;
          write_d = tag_fifo_rdata_i[ADDR_WIDTH+TID_WIDTH];
          tid_d   = tag_fifo_rdata_i[ADDR_WIDTH +: TID_WIDTH];
          addr_d  = tag_fifo_rdata_i[ADDR_WIDTH-1:0];
          state_d = S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        rready = 1'b1;
        if (rvalid_i) begin
          hit_d   = rdata_i[TAG_WIDTH] &&
                    (rdata_i[TAG_WIDTH-1:0] == addr_q[ADDR_WIDTH-1 -: TAG_WIDTH]);
          dirty_d = rdata_i[TAG_WIDTH] && rdata_i[TAG_WIDTH+1];
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        res_valid = 1'b1;
        if (res_ready_i) begin
          handshake = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Statistics: a clear overrides an increment in the same cycle.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (cnt_clr_i) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (handshake) begin
      if (hit_q) hit_cnt_d  = sat_inc(hit_cnt_q);
      else       miss_cnt_d = sat_inc(miss_cnt_q);
    end
  end

  // State, captured request, compare result and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      tid_q      <= '0;
      addr_q     <= '0;
      hit_q      <= 1'b0;
      dirty_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      tid_q      <= tid_d;
      addr_q     <= addr_d;
      hit_q      <= hit_d;
      dirty_q    <= dirty_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Handshake strobes are forced low while reset is held so nothing is
  // popped, accepted or presented during a mid-operation reset.
  assign tag_fifo_rden_o = rden      && !rst;
  assign rready_o        = rready    && !rst;
  assign res_valid_o     = res_valid && !rst;
  assign res_hit_o       = hit_q;
  assign res_dirty_o     = dirty_q;
  assign res_write_o     = write_q;
  assign res_tid_o       = tid_q;
  assign res_addr_o      = addr_q;
  assign hit_cnt_o       = hit_cnt_q;
  assign miss_cnt_o      = miss_cnt_q;

endmodule

// File: doc/tag_check_scheduler.md
Name: tag_check_scheduler

Overview:
- Sequences the tag-check stage of the DRAM cache controller.
- Pops one request entry (read/write flag, TID, full address) from the tag FIFO written by the index extractor.
- Pairs the entry with the in-order tag-read response returning from the memory controller R channel, compares tags, and presents one hit/miss result per request to the downstream data-path controller.
- Keeps saturating hit/miss statistics counters.

Parameters:
- ADDR_WIDTH, 64, request address width.
- TID_WIDTH, 16, transaction ID width carried in the tag FIFO entry.
- INDEX_WIDTH, 20, cache set index width.
- OFFSET_WIDTH, 6, line offset width.
- TAG_WIDTH, ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH, stored tag width (derived).
- DATA_WIDTH, 512, memory R channel data width.
- CNT_WIDTH, 32, statistics counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- tag_fifo_empty_i  in  1  tag FIFO empty.
- tag_fifo_rdata_i  in  ADDR_WIDTH+TID_WIDTH+1  FWFT head entry: [top]=is_write, [ADDR_WIDTH+TID_WIDTH-1:ADDR_WIDTH]=tid, [ADDR_WIDTH-1:0]=addr.
- tag_fifo_rden_o  out  1  pop head entry.
- rvalid_i  in  1  tag-read response valid.
- rdata_i  in  DATA_WIDTH  tag-read data: [TAG_WIDTH-1:0]=stored tag, [TAG_WIDTH]=line valid, [TAG_WIDTH+1]=line dirty.
- rready_o  out  1  response accept.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result accepted by downstream.
- res_hit_o  out  1  tag hit.
- res_dirty_o  out  1  victim line valid and dirty (writeback needed on miss).
- res_write_o  out  1  request was a write.
- res_tid_o  out  TID_WIDTH  request TID.
- res_addr_o  out  ADDR_WIDTH  request address.
- cnt_clr_i  in  1  clear statistics counters.
- hit_cnt_o  out  CNT_WIDTH  hit count.
- miss_cnt_o  out  CNT_WIDTH  miss count.

Behaviour:
- States: S_IDLE, S_WAIT_R, S_OUT.
- Reset: state = S_IDLE, all result registers 0, counters 0. All outputs read 0, including tag_fifo_rden_o, rready_o and res_valid_o. Reset mid-operation drops the in-flight entry and any pending result. Nothing is replayed.
- S_IDLE:
  - tag_fifo_rden_o = !tag_fifo_empty_i (combinational, one-cycle pulse).
  - When non-empty: latch the is_write, tid and addr fields of tag_fifo_rdata_i on the same edge; go to S_WAIT_R.
  - rready_o = 0. An R response arriving in S_IDLE is back-pressured, not dropped.
- S_WAIT_R:
  - rready_o = 1; tag_fifo_rden_o = 0.
  - On rvalid_i:
    - hit = rdata_i[TAG_WIDTH] && (rdata_i[TAG_WIDTH-1:0] == latched addr[ADDR_WIDTH-1:INDEX_WIDTH+OFFSET_WIDTH]).
    - dirty = rdata_i[TAG_WIDTH] && rdata_i[TAG_WIDTH+1].
    - Register hit and dirty; go to S_OUT.
- S_OUT:
  - res_valid_o = 1; result outputs hold stable until the handshake.
  - On res_ready_i: go to S_IDLE. In the same cycle, increment hit_cnt_o if hit, else miss_cnt_o.
- Latency: pop at cycle T. Earliest R accept T+1. res_valid_o high from T+2. Earliest next pop T+3 (same-cycle handshake).
- Throughput: at most one request in flight. Strict FIFO order is guaranteed because responses return in issue order.
- Counters saturate at all-ones and never wrap.
- cnt_clr_i zeroes both counters. If it coincides with a result handshake, the clear wins and the increment is lost.
- Out-of-range inputs: rdata_i bits above TAG_WIDTH+1 are ignored. The is_write flag does not affect the compare.

Test Plan:
- Reset then idle: hold rst 2 cycles with FIFO empty and rvalid_i=1 -> all outputs 0, rready_o stays 0, counters 0.
- Read hit: push {0, tid=5, addr=0x0000_1234_5678_9AC0}; R data tag=addr[63:26], valid=1, dirty=0 -> res_hit_o=1, res_tid_o=5, res_write_o=0, result valid 2 cycles after pop, hit_cnt_o=1 after handshake.
- Write miss with dirty victim: push {1, tid=0, addr}; R data with mismatched tag, valid=1, dirty=1 -> res_hit_o=0, res_dirty_o=1, res_write_o=1, miss_cnt_o=1.
- Back-pressure: hold res_ready_i=0 for 10 cycles with FIFO non-empty -> result stable, no second pop; releasing res_ready_i pops the next entry the following cycle. Early R with empty FIFO -> rready_o=0 until an entry is popped.
- Invalid line: stored tag equal to the address tag but valid=0 -> miss, res_dirty_o=0.
- Saturation and clear: force hit_cnt_o to 0xFFFF_FFFF, complete a hit -> stays 0xFFFF_FFFF. Assert cnt_clr_i together with a handshake -> both counters read 0 next cycle.
